pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter register and instruction-fetch sequencer for the single-cycle CPU. It sits directly downstream of the PC-select mux:
- It holds the architectural PC and supplies the sequential successor (PC+4) back to the mux.
- It fetches each instruction from instruction memory over a request/acknowledge handshake.
- It holds the fetched word for the datapath until the core releases it.
- On accept, it commits the mux-selected PC.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned (bits [1:0] = 0), otherwise elaboration error.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST_N  input  1  reset is asynchronous and active-low.
- PC_IN  input  32  selected next PC from the PC-select mux.
- STALL  input  1  core holds the current instruction; PC update blocked while high.
- IMEM_ACK  input  1  instruction memory has IMEM_RDATA valid for the current request.
- IMEM_RDATA  input  32  instruction word from memory.
- PC  output  32  current PC (registered).
- NEXT  output  32  PC + 4, combinational, to the mux NEXT input.
- IMEM_REQ  output  1  fetch request.
- IMEM_ADDR  output  32  fetch address; equals PC.
- INSTR  output  32  captured instruction word (registered).
- INSTR_VALID  output  1  INSTR holds the instruction at PC.
- MISALIGNED  output  1  sticky fault: misaligned PC_IN was presented for commit.

## Operation
- FSM states: IDLE, REQ, EXEC, TRAP. Reset state is IDLE.
- IDLE: always goes to REQ on the next edge.
- REQ:
  - IMEM_REQ=1 and IMEM_ADDR=PC, both held stable until IMEM_ACK.
  - On an edge with IMEM_ACK=1: INSTR<=IMEM_RDATA, INSTR_VALID<=1, go to EXEC.
  - IMEM_ACK in any other state is ignored.
- EXEC:
  - IMEM_REQ=0. INSTR and INSTR_VALID hold while STALL=1.
  - Accept condition: STALL=0 and PC_IN[1:0]=0. On accept: PC<=PC_IN, INSTR_VALID<=0, go to REQ.
  - If STALL=0 and PC_IN[1:0]≠0: PC is not updated, MISALIGNED<=1, INSTR_VALID<=0, go to TRAP.
- TRAP: absorbing. IMEM_REQ=0, MISALIGNED=1. Only reset exits.
- NEXT = PC + 32'd4, truncated to 32 bits. 32'hFFFF_FFFC wraps to 32'h0000_0000; no flag.
- PC_IN may depend combinationally on NEXT through the mux. There is no loop, because PC is registered.

## Timing
- Reset (asynchronous, any state, including mid-request): state=IDLE, PC=RESET_VECTOR, INSTR=0, INSTR_VALID=0, MISALIGNED=0.
  - IMEM_REQ=0 while RST_N=0 and in the first cycle after release.
  - A request in flight when reset asserts is abandoned; a late IMEM_ACK is ignored.
- First IMEM_REQ is asserted in the second cycle after RST_N rises (IDLE→REQ takes one edge).
- Fetch latency: INSTR_VALID rises on the same edge IMEM_ACK is sampled high. A zero-wait memory gives REQ-to-valid in 1 cycle.
- Throughput with zero-wait memory and STALL=0: one instruction per 2 cycles (REQ, EXEC).
- PC changes only on the edge leaving EXEC with accept. PC is constant across REQ cycles, so IMEM_ADDR is stable for the whole request.
- STALL is sampled only in EXEC; STALL high during REQ has no effect.

## Structure
- Shared package cpu_pkg: fetch-state enum (IDLE, REQ, EXEC, TRAP), WORD_BYTES=4, XLEN=32.
- No sub-module required; the +4 adder is inline.

## Test plan
- Reset: hold RST_N=0 with RESET_VECTOR=32'h0000_0100 → PC=0x100, NEXT=0x104, IMEM_REQ=0, INSTR_VALID=0. Release → IMEM_REQ=1 with IMEM_ADDR=0x100 one cycle later.
- Wait-state fetch: IMEM_ACK low for 3 cycles, then high with RDATA=0x00A00093 → IMEM_ADDR stable at 0x100 for all 4 REQ cycles. INSTR=0x00A00093 and INSTR_VALID=1 after the ACK edge.
- Stall hold and commit: STALL=1 for 5 cycles in EXEC → INSTR and PC unchanged, IMEM_REQ=0. STALL=0 with PC_IN=0x200 → PC=0x200, next IMEM_ADDR=0x200.
- Sequential wrap: PC=0xFFFF_FFFC, PC_IN driven from NEXT → NEXT=0x0000_0000; after accept, PC=0 and the fetch goes to 0x0.
- Misaligned: in EXEC, PC_IN=0x202 with STALL=0 → MISALIGNED=1 and PC stays at its old value. No further IMEM_REQ for 10 cycles; IMEM_ACK pulses are ignored.
- Reset mid-request: assert RST_N low during REQ, then pulse IMEM_ACK after release while in IDLE → INSTR_VALID stays 0. PC=RESET_VECTOR, MISALIGNED cleared.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared CPU definitions used by the fetch stage: word size, byte width of an
// instruction word, and the fetch-sequencer state encoding.
package cpu_pkg;
  localparam int XLEN       = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2,
    TRAP = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/acknowledge channel between the fetch stage
// (master) and instruction memory (slave).
interface pc_fetch_if;
  import cpu_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/pc_fetch.sv
// Program-counter register and instruction-fetch sequencer: fetches the word at
// PC, holds it for the core, and commits the mux-selected PC on accept.
module pc_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_in,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic            misaligned,
  pc_fetch_if.master      imem
);

  generate
    if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_vector
      $error("pc_fetch: RESET_VECTOR must be word-aligned");
    end
  endgenerate

  fetch_state_e state, state_nxt;
  logic         pc_in_aligned;
  logic         accept;
  logic         fault;

  assign pc_in_aligned = (pc_in[1:0] == 2'b00);
  assign accept        = (state == EXEC) && !stall && pc_in_aligned;
  assign fault         = (state == EXEC) && !stall && !pc_in_aligned;

  // Sequential successor; wraps silently at the top of the address space.
  assign next = pc + XLEN'(WORD_BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ:  if (imem.imem_ack) state_nxt = EXEC;
      EXEC: if (accept)        state_nxt = REQ;
            else if (fault)    state_nxt = TRAP;
      TRAP: state_nxt = TRAP;
      default: state_nxt = IDLE;
    endcase
  end

  // Address comes straight from the PC register, so it cannot move mid-request.
  always_comb begin
    imem.imem_req  = (state == REQ);
    imem.imem_addr = pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_VECTOR;
      instr       <= '0;
      instr_valid <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      if (state == REQ && imem.imem_ack) begin
        instr       <= imem.imem_rdata;
        instr_valid <= 1'b1;
      end
      if (accept) begin
        pc          <= pc_in;
        instr_valid <= 1'b0;
      end
      if (fault) begin
        misaligned  <= 1'b1;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: reset, wait-state fetch, stall/commit,
// sequential wrap, misaligned trap and reset during an outstanding request.
module tb_pc_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in_reg;
  logic        use_next;
  logic [31:0] pc_in;
  logic        stall;
  logic [31:0] pc, next, instr;
  logic        instr_valid, misaligned;
  int          total = 0;
  int          passed = 0;

  pc_fetch_if imem ();

  pc_fetch #(.RESET_VECTOR(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .stall(stall),
    .pc(pc), .next(next), .instr(instr), .instr_valid(instr_valid),
    .misaligned(misaligned), .imem(imem.master)
  );

  always #5 clk = ~clk;

  // The PC-select mux: either a directed target or the sequential successor.
  assign pc_in = use_next ? next : pc_in_reg;

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b1; use_next = 1'b0; pc_in_reg = 32'h0;
    imem.imem_ack = 1'b0; imem.imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    total++; if (pc !== 32'h100) $display("FAIL rst_pc got %h want %h", pc, 32'h100); else passed++;
    total++; if (next !== 32'h104) $display("FAIL rst_next got %h want %h", next, 32'h104); else passed++;
    total++; if (imem.imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", imem.imem_req); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", instr_valid); else passed++;
    total++; if (misaligned !== 1'b0) $display("FAIL rst_mis got %b want 0", misaligned); else passed++;
    rst_n = 1'b1;
    #1;
    total++; if (imem.imem_req !== 1'b0) $display("FAIL rel_req got %b want 0", imem.imem_req); else passed++;
    @(negedge clk);
    total++; if (imem.imem_req !== 1'b1) $display("FAIL first_req got %b want 1", imem.imem_req); else passed++;
    total++; if (imem.imem_addr !== 32'h100) $display("FAIL first_addr got %h want %h", imem.imem_addr, 32'h100); else passed++;
  endtask

  task automatic test_wait_fetch();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h100)
        $display("FAIL wait_req[%0d] got req=%b addr=%h want req=1 addr=%h", i, imem.imem_req, imem.imem_addr, 32'h100);
      else passed++;
      total++; if (instr_valid !== 1'b0) $display("FAIL wait_valid[%0d] got %b want 0", i, instr_valid); else passed++;
    end
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h00A0_0093;
    @(negedge clk);
    imem.imem_ack = 1'b0;
    total++; if (instr !== 32'h00A0_0093) $display("FAIL fetch_instr got %h want %h", instr, 32'h00A0_0093); else passed++;
    total++; if (instr_valid !== 1'b1) $display("FAIL fetch_valid got %b want 1", instr_valid); else passed++;
    total++; if (imem.imem_req !== 1'b0) $display("FAIL exec_req got %b want 0", imem.imem_req); else passed++;
  endtask

  task automatic test_stall_commit();
    pc_in_reg = 32'h200;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (instr !== 32'h00A0_0093 || instr_valid !== 1'b1)
        $display("FAIL stall_instr[%0d] got %h/%b want %h/1", i, instr, instr_valid, 32'h00A0_0093);
      else passed++;
      total++; if (pc !== 32'h100 || imem.imem_req !== 1'b0)
        $display("FAIL stall_pc[%0d] got pc=%h req=%b want pc=%h req=0", i, pc, imem.imem_req, 32'h100);
      else passed++;
    end
    stall = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    total++; if (pc !== 32'h200) $display("FAIL commit_pc got %h want %h", pc, 32'h200); else passed++;
    total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h200)
      $display("FAIL commit_fetch got req=%b addr=%h want req=1 addr=%h", imem.imem_req, imem.imem_addr, 32'h200);
    else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL commit_valid got %b want 0", instr_valid); else passed++;
  endtask

  task automatic test_wrap();
    pc_in_reg = 32'hFFFF_FFFC; stall = 1'b0;
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h0000_0013;
    @(negedge clk);
    imem.imem_ack = 1'b0;
    total++; if (instr !== 32'h0000_0013) $display("FAIL wrap_instr got %h want %h", instr, 32'h13); else passed++;
    @(negedge clk);
    total++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got %h want %h", pc, 32'hFFFF_FFFC); else passed++;
    total++; if (next !== 32'h0) $display("FAIL wrap_next got %h want %h", next, 32'h0); else passed++;
    use_next = 1'b1;
    imem.imem_ack = 1'b1;
    @(negedge clk);
    imem.imem_ack = 1'b0;
    @(negedge clk);
    total++; if (pc !== 32'h0) $display("FAIL wrap_commit got %h want %h", pc, 32'h0); else passed++;
    total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0)
      $display("FAIL wrap_fetch got req=%b addr=%h want req=1 addr=%h", imem.imem_req, imem.imem_addr, 32'h0);
    else passed++;
  endtask

  task automatic test_misaligned();
    use_next = 1'b0; pc_in_reg = 32'h202; stall = 1'b1;
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h0000_0033;
    @(negedge clk);
    imem.imem_ack = 1'b0;
    total++; if (instr_valid !== 1'b1) $display("FAIL mis_pre_valid got %b want 1", instr_valid); else passed++;
    stall = 1'b0;
    @(negedge clk);
    total++; if (misaligned !== 1'b1) $display("FAIL mis_flag got %b want 1", misaligned); else passed++;
    total++; if (pc !== 32'h0) $display("FAIL mis_pc got %h want %h", pc, 32'h0); else passed++;
    for (int i = 0; i < 10; i++) begin
      imem.imem_ack = (i % 2 == 0);
      @(negedge clk);
      total++; if (imem.imem_req !== 1'b0 || instr_valid !== 1'b0 || misaligned !== 1'b1)
        $display("FAIL trap_hold[%0d] got req=%b valid=%b mis=%b want 0/0/1", i, imem.imem_req, instr_valid, misaligned);
      else passed++;
    end
    imem.imem_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    stall = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (imem.imem_req !== 1'b1) $display("FAIL mid_req got %b want 1", imem.imem_req); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (imem.imem_req !== 1'b0) $display("FAIL mid_rst_req got %b want 0", imem.imem_req); else passed++;
    total++; if (pc !== 32'h100 || misaligned !== 1'b0)
      $display("FAIL mid_rst_state got pc=%h mis=%b want pc=%h mis=0", pc, misaligned, 32'h100);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem.imem_ack = 1'b0;
    total++; if (instr_valid !== 1'b0) $display("FAIL late_ack_valid got %b want 0", instr_valid); else passed++;
    total++; if (instr !== 32'h0) $display("FAIL late_ack_instr got %h want %h", instr, 32'h0); else passed++;
    total++; if (imem.imem_req !== 1'b1 || pc !== 32'h100)
      $display("FAIL post_rst_fetch got req=%b pc=%h want req=1 pc=%h", imem.imem_req, pc, 32'h100);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_wait_fetch();
    test_stall_commit();
    test_wrap();
    test_misaligned();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
